// File: rtl/spi_sched_pkg.sv
// Shared types and defaults for the SPI transfer scheduler.
// Holds the scheduler FSM state enum and default WIDTH/NREQ.
package spi_sched_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 3;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
// Ports: req (in), ptr (in), grant one-hot (out), winner index (out).
module spi_rr_arbiter
  import spi_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   winner
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IW'((int'(ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = idx;
      end
    end
  end

endmodule

// File: rtl/spi_xfer_scheduler.sv
// Shares one SPI master among NREQ requesters, one slave select each.
// Ports: clk, rst (async low), req/tx_data in; grant/done/rx_data/busy out;
// spi_load/spi_data/spi_ss to master, spi_rx from master.
module spi_xfer_scheduler
  import spi_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] tx_data,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      rx_data,
  output logic                  busy,
  output logic                  spi_load,
  output logic [WIDTH-1:0]      spi_data,
  output logic [NREQ-1:0]       spi_ss,
  input  logic [WIDTH-1:0]      spi_rx
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NREQ - 1);

  state_t          state;
  state_t          state_d;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   arb_win;
  logic [NREQ-1:0] arb_gnt;
  logic [CW-1:0]   cnt;

  spi_rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req    (req),
    .ptr    (ptr),
    .grant  (arb_gnt),
    .winner (arb_win)
  );

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (|req) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (cnt == CNT_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode from state so an async reset drops them at once.
  always_comb begin
    busy     = 1'b0;
    spi_load = 1'b0;
    spi_ss   = '0;
    done     = '0;
    unique case (state)
      IDLE:  ;
      LOAD: begin
        busy     = 1'b1;
        spi_load = 1'b1;
      end
      SHIFT: begin
        busy   = 1'b1;
        spi_ss = grant;
      end
      DONE: begin
        busy = 1'b1;
        done = grant;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      cnt      <= '0;
      grant    <= '0;
      spi_data <= '0;
      rx_data  <= '0;
    end else begin
      state <= state_d;
      unique case (state)
        IDLE: begin
          if (|req) begin
            grant    <= arb_gnt;
            owner    <= arb_win;
            spi_data <= tx_data[arb_win*WIDTH +: WIDTH];
          end
        end
        LOAD: cnt <= '0;
        SHIFT: begin
          if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
        end
        DONE: begin
          rx_data <= spi_rx;
          grant   <= '0;
          ptr     <= (owner == IDX_LAST) ? '0 : owner + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_scheduler.sv
// Bench for spi_xfer_scheduler: directed scenarios plus random traffic
// checked every cycle against a transfer-level reference model.
module tb_spi_xfer_scheduler;

  localparam int W = 8;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] tx_data = '0;
  logic [W-1:0] spi_rx = '0;

  logic [N-1:0] grant, done, spi_ss;
  logic [W-1:0] rx_data, spi_data;
  logic         busy, spi_load;

  always #5 clk = ~clk;

  spi_xfer_scheduler #(.WIDTH(W), .NREQ(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .tx_data  (tx_data),
    .grant    (grant),
    .done     (done),
    .rx_data  (rx_data),
    .busy     (busy),
    .spi_load (spi_load),
    .spi_data (spi_data),
    .spi_ss   (spi_ss),
    .spi_rx   (spi_rx)
  );

  int nchk = 0;
  int npass = 0;
  int ss_run = 0;
  int n_g1 = 0;
  int n_done = 0;

  // Transfer-level model: a transfer occupies W+2 cycles after the grant
  // edge (t=0 load, t=1..W select, t=W+1 done).
  bit           m_busy;
  int           m_t, m_owner, m_ptr;
  logic [W-1:0] m_data, m_rx;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++)
      if (r[(p + i) % N]) return (p + i) % N;
    return 0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0; m_t <= 0; m_owner <= 0; m_ptr <= 0;
      m_data <= '0; m_rx <= '0;
    end else if (!m_busy) begin
      if (|req) begin
        m_busy  <= 1'b1;
        m_t     <= 0;
        m_owner <= pick(req, m_ptr);
        m_data  <= tx_data[pick(req, m_ptr)*W +: W];
      end
    end else if (m_t == W + 1) begin
      m_busy <= 1'b0;
      m_ptr  <= (m_owner + 1) % N;
      m_rx   <= spi_rx;
    end else begin
      m_t <= m_t + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic compare_all();
    logic [N-1:0] one, eg, ess, edn;
    one = 1;
    eg  = m_busy ? (one << m_owner) : '0;
    ess = (m_busy && m_t >= 1 && m_t <= W) ? eg : '0;
    edn = (m_busy && m_t == W + 1) ? eg : '0;
    check("grant", grant, eg);
    check("spi_ss", spi_ss, ess);
    check("done", done, edn);
    check("busy", busy, m_busy);
    check("spi_load", spi_load, m_busy && m_t == 0);
    check("spi_data", spi_data, m_data);
    check("rx_data", rx_data, m_rx);
    check("ss_onehot0", $onehot0(spi_ss), 1);
    check("ss_in_load", spi_load && (spi_ss != 0), 0);
    if (grant == 3'b010) n_g1++;
    if (done != 0) n_done++;
    if (!rst) ss_run = 0;
    else begin
      if (spi_ss != 0) ss_run++;
      if (done != 0) begin
        check("ss_run", ss_run, W);
        ss_run = 0;
      end
    end
  endtask

  // Compare at the negedge, then return 2 time units after the next posedge.
  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  logic [W-1:0] rxs;
  logic [W-1:0] bytes [3];
  int           snap;

  initial begin
    repeat (2) @(posedge clk);
    #2;
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_ss", spi_ss, 0);
    check("rst_data", spi_data, 0);
    check("rst_rx", rx_data, 0);
    rst = 1'b1;
    tick();

    // Single request from requester 0.
    tx_data[0 +: W] = 8'hFF;
    req = 3'b001;
    tick();
    check("t1_load", spi_load, 1);
    check("t1_ss_in_load", spi_ss, 0);
    check("t1_data", spi_data, 8'hFF);
    for (int j = 2; j <= 9; j++) begin
      tick();
      check("t1_ss", spi_ss, 3'b001);
    end
    tick();
    check("t1_done", done, 3'b001);
    rxs = 8'h96;
    spi_rx = rxs;
    req = '0;
    tick();
    check("t1_rx", rx_data, rxs);
    check("t1_idle", busy, 0);
    tick();

    // Pointer now at 1: requester 2 beats requester 0.
    tx_data[0 +: W] = 8'h11;
    tx_data[2*W +: W] = 8'h22;
    req = 3'b101;
    tick();
    check("fair_g2", grant, 3'b100);
    check("fair_d2", spi_data, 8'h22);
    repeat (9) tick();
    check("fair_done2", done, 3'b100);
    req = 3'b001;
    tick();
    tick();
    check("fair_g0", grant, 3'b001);
    check("fair_d0", spi_data, 8'h11);
    req = '0;
    repeat (11) tick();

    // Contention from reset: strict rotation 0,1,2,0.
    do_reset();
    bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'h0F;
    tx_data = {bytes[2], bytes[1], bytes[0]};
    req = 3'b111;
    for (int r = 0; r < 4; r++) begin
      tick();
      check("cont_grant", grant, 32'(1) << (r % 3));
      check("cont_data", spi_data, bytes[r % 3]);
      if (r < 3) repeat (10) tick();
    end
    req = '0;
    repeat (12) tick();

    // One-cycle pulse on requester 1 while 0 is being served.
    snap = n_g1;
    req = 3'b001;
    tick();
    repeat (3) tick();
    req = 3'b011;
    tick();
    req = 3'b001;
    repeat (5) tick();
    check("wd_done0", done, 3'b001);
    req = '0;
    repeat (20) tick();
    check("wd_no_g1", n_g1, snap);

    // Reset during the fourth shift cycle.
    req = 3'b001;
    tick();
    repeat (4) tick();
    check("mr_ss_pre", spi_ss, 3'b001);
    #1 rst = 1'b0;
    #1;
    check("mr_ss", spi_ss, 0);
    check("mr_busy", busy, 0);
    check("mr_grant", grant, 0);
    req = '0;
    snap = n_done;
    tick();
    tick();
    rst = 1'b1;
    repeat (12) tick();
    check("mr_no_done", n_done, snap);
    tx_data[2*W +: W] = 8'h5A;
    req = 3'b100;
    tick();
    check("mr_load", spi_load, 1);
    check("mr_grant2", grant, 3'b100);
    check("mr_data", spi_data, 8'h5A);
    repeat (9) tick();
    check("mr_done", done, 3'b100);
    rxs = 8'hC3;
    spi_rx = rxs;
    req = '0;
    tick();
    check("mr_rx", rx_data, rxs);

    // Random traffic: requesters hold once granted, may withdraw otherwise.
    repeat (2000) begin
      spi_rx = W'($urandom);
      for (int i = 0; i < N; i++) begin
        if (!(m_busy && m_owner == i)) begin
          if (req[i]) begin
            if ($urandom_range(3) == 0) req[i] = 1'b0;
          end else if ($urandom_range(2) == 0) begin
            tx_data[i*W +: W] = W'($urandom);
            req[i] = 1'b1;
          end
        end
      end
      tick();
    end
    req = '0;
    repeat (15) tick();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
